// File: rtl/toom3_gf2_mult_seq.sv
// toom3_gf2_mult_seq: sequential carry-less (GF(2)[x]) multiplier built on a
// 3-way operand split. Each operand is cut into three S-bit limbs. The nine
// limb sub-products are accumulated DIGIT bits of the a-limb per cycle. They
// are then folded into five coefficient terms and recombined into the
// 2*WIDTH-bit product.
module toom3_gf2_mult_seq #(
  parameter int WIDTH = 192,
  parameter int DIGIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] c
);

  localparam int S   = WIDTH / 3;          // limb width
  localparam int K   = S / DIGIT;          // digit steps per product
  localparam int P   = 2 * S - 1;          // limb sub-product width
  localparam int CW  = $clog2(K) + 1;      // digit counter width
  localparam int C_W = 2 * WIDTH;          // full product width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    COMB = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [S-1:0]   a_r [3];
  logic [S-1:0]   b_r [3];
  logic [P-1:0]   p_r [9];
  logic [P-1:0]   p_next_s [9];
  logic [P-1:0]   h_r, g_r, f_r, e_r, d_r;
  logic [C_W-1:0] c_next_s;
  int             base_s;

  // One digit of a-limb times a full b-limb, placed at bit offset 'base'.
  // Index math never exceeds 2S-2, so the result fits the P-bit accumulator.
  function automatic logic [P-1:0] digit_clmul(input logic [DIGIT-1:0] ad,
                                               input logic [S-1:0]     bj,
                                               input int               base);
    logic [P-1:0] acc;
    acc = '0;
    for (int t = 0; t < DIGIT; t++) begin
      if (ad[t]) begin
        acc = acc ^ (P'(bj) << (base + t));
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Next accumulator values for the current digit step, all nine pairs at once.
  always_comb begin
    base_s = int'(cnt_r) * DIGIT;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        p_next_s[3*i+j] = p_r[3*i+j] ^
                          digit_clmul(DIGIT'(a_r[i] >> base_s), b_r[j], base_s);
      end
    end
  end

  // Recombine the five coefficient terms at limb-sized offsets.
  always_comb begin
    c_next_s = C_W'(h_r)
             ^ (C_W'(g_r) << S)
             ^ (C_W'(f_r) << (2 * S))
             ^ (C_W'(e_r) << (3 * S))
             ^ (C_W'(d_r) << (4 * S));
  end

  // Control FSM plus all datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ready   <= 1'b1;
      done    <= 1'b0;
      c       <= '0;
      h_r     <= '0;
      g_r     <= '0;
      f_r     <= '0;
      e_r     <= '0;
      d_r     <= '0;
      for (int i = 0; i < 3; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
      for (int i = 0; i < 9; i++) begin
        p_r[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r[0]  <= a[S-1:0];
            a_r[1]  <= a[2*S-1:S];
            a_r[2]  <= a[3*S-1:2*S];
            b_r[0]  <= b[S-1:0];
            b_r[1]  <= b[2*S-1:S];
            b_r[2]  <= b[3*S-1:2*S];
            for (int i = 0; i < 9; i++) begin
              p_r[i] <= '0;
            end
            cnt_r   <= '0;
            ready   <= 1'b0;
            state_r <= MUL;
          end else begin
            ready   <= 1'b1;
            state_r <= IDLE;
          end
        end
        MUL: begin
          for (int i = 0; i < 9; i++) begin
            p_r[i] <= p_next_s[i];
          end
          // Wrap rather than overrun so cnt stays within 0..K-1.
          if (cnt_r == CW'(K - 1)) begin
            cnt_r   <= '0;
            state_r <= COMB;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            state_r <= MUL;
          end
        end
        COMB: begin
          h_r     <= p_r[0];
          g_r     <= p_r[1] ^ p_r[3];
          f_r     <= p_r[2] ^ p_r[4] ^ p_r[6];
          e_r     <= p_r[5] ^ p_r[7];
          d_r     <= p_r[8];
          state_r <= OUT;
        end
        OUT: begin
          c       <= c_next_s;
          done    <= 1'b1;
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toom3_gf2_mult_seq.sv
// tb_toom3_gf2_mult_seq: self-checking bench for the 3-way carry-less
// multiplier. Four instances cover the default and sweep configurations, and
// all results are checked against a bitwise shift-and-XOR reference.
module tb_toom3_gf2_mult_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   start_v = 4'b0000;
  logic [383:0] a_in = '0;
  logic [383:0] b_in = '0;
  logic [3:0]   ready_v;
  logic [3:0]   done_v;
  logic [383:0] c0;
  logic [23:0]  c1;
  logic [23:0]  c2;
  logic [767:0] c3;
  logic [767:0] c_v [4];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  // Instance 0: 192/4 (K=16), 1: 12/1 (K=4), 2: 12/4 (K=1), 3: 384/8 (K=16).
  toom3_gf2_mult_seq #(.WIDTH(192), .DIGIT(4)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[191:0]), .b(b_in[191:0]),
    .ready(ready_v[0]), .done(done_v[0]), .c(c0));
  toom3_gf2_mult_seq #(.WIDTH(12), .DIGIT(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in[11:0]), .b(b_in[11:0]),
    .ready(ready_v[1]), .done(done_v[1]), .c(c1));
  toom3_gf2_mult_seq #(.WIDTH(12), .DIGIT(4)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[11:0]), .b(b_in[11:0]),
    .ready(ready_v[2]), .done(done_v[2]), .c(c2));
  toom3_gf2_mult_seq #(.WIDTH(384), .DIGIT(8)) u3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .a(a_in), .b(b_in),
    .ready(ready_v[3]), .done(done_v[3]), .c(c3));

  assign c_v[0] = 768'(c0);
  assign c_v[1] = 768'(c1);
  assign c_v[2] = 768'(c2);
  assign c_v[3] = c3;

  // Schoolbook carry-less product: XOR a shifted copy of b for every set bit of a.
  function automatic logic [767:0] clmul_ref(input logic [383:0] av, input logic [383:0] bv);
    logic [767:0] r;
    r = '0;
    for (int i = 0; i < 384; i++) begin
      if (av[i]) r = r ^ (768'(bv) << i);
    end
    return r;
  endfunction

  function automatic logic [383:0] rand_op(input int w);
    logic [383:0] r;
    logic [383:0] m;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    m = (384'(1) << w) - 384'(1);
    return r & m;
  endfunction

  // Launch one operation on instance k (caller sits at a negedge) and check
  // latency K+2, ready in the done cycle, and the product. Returns at the
  // negedge of the done cycle so a following call is back-to-back.
  task automatic run_op(input int k, input int kk, input logic [383:0] av,
                        input logic [383:0] bv, input logic [767:0] exp, input string name);
    int n;
    checks++;
    if (ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready inst=%0d got %b expected 1", name, k, ready_v[k]);
    end
    a_in = av;
    b_in = bv;
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    a_in = rand_op(384);
    b_in = rand_op(384);
    n = 0;
    while (done_v[k] !== 1'b1 && n < kk + 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_v[k] !== 1'b1 || n != kk + 2 || ready_v[k] !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency inst=%0d got done=%b ready=%b at %0d expected done=1 ready=1 at %0d",
               name, k, done_v[k], ready_v[k], n, kk + 2);
    end
    checks++;
    if (c_v[k] !== exp) begin
      errors++;
      $display("FAIL %s_c inst=%0d got %h expected %h", name, k, c_v[k], exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ready_v !== 4'hF || done_v !== 4'h0 || c_v[0] !== '0 || c_v[1] !== '0 ||
          c_v[2] !== '0 || c_v[3] !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d got ready=%b done=%b c0=%h expected ready=1111 done=0000 c=0",
                 i, ready_v, done_v, c_v[0]);
      end
    end
  endtask

  task automatic test_simple();
    run_op(0, 16, 384'd1, 384'd1, 768'd1, "one_times_one");
    run_op(0, 16, 384'd3, 384'd3, 768'd5, "three_sq");
  endtask

  task automatic test_corners();
    logic [383:0] top;
    logic [767:0] e;
    top = 384'(1) << 191;
    e = 768'(1) << 382;
    run_op(0, 16, top, top, e, "top_sq");
    e = 768'(1) << 191;
    run_op(0, 16, top, 384'd1, e, "top_times_one");
  endtask

  task automatic test_back_to_back();
    logic [383:0] ones;
    logic [767:0] e;
    ones = (384'(1) << 192) - 384'(1);
    e = '0;
    for (int i = 0; i < 192; i++) e[2*i] = 1'b1;
    run_op(0, 16, ones, ones, e, "square_ones");
    run_op(0, 16, 384'd0, ones, 768'd0, "b2b_zero");
  endtask

  task automatic test_random_default();
    logic [383:0] x;
    logic [383:0] y;
    for (int i = 0; i < 20; i++) begin
      x = rand_op(192);
      y = rand_op(192);
      run_op(0, 16, x, y, clmul_ref(x, y), "rand_default");
    end
  endtask

  task automatic test_ignored_start();
    logic [383:0] x;
    logic [383:0] y;
    logic [767:0] e;
    int dones;
    int done_at;
    x = rand_op(192);
    y = rand_op(192);
    e = clmul_ref(x, y);
    a_in = x;
    b_in = y;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    dones = 0;
    done_at = -1;
    for (int n = 1; n <= 36; n++) begin
      if (n == 3 || n == 10) begin
        start_v[0] = 1'b1;
        a_in = rand_op(192);
        b_in = rand_op(192);
      end else begin
        start_v[0] = 1'b0;
      end
      @(negedge clk);
      if (done_v[0] === 1'b1) begin
        dones++;
        if (done_at < 0) done_at = n;
      end
    end
    checks++;
    if (dones != 1 || done_at != 18) begin
      errors++;
      $display("FAIL busy_start_ignored got dones=%0d first_at=%0d expected dones=1 at 18", dones, done_at);
    end
    checks++;
    if (c_v[0] !== e) begin
      errors++;
      $display("FAIL busy_start_c got %h expected %h", c_v[0], e);
    end
  endtask

  task automatic test_reset_mid_op();
    int dones;
    a_in = rand_op(192) | 384'd1;
    b_in = rand_op(192) | 384'd1;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int n = 1; n <= 7; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1 || done_v[0] !== 1'b0 || c_v[0] !== '0) begin
      errors++;
      $display("FAIL midop_reset got ready=%b done=%b c=%h expected ready=1 done=0 c=0",
               ready_v[0], done_v[0], c_v[0]);
    end
    rst = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midop_no_done got dones=%0d expected 0", dones);
    end
    // Reset and start together: reset wins, so nothing is accepted.
    rst = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_over_start got ready=%b expected 1", ready_v[0]);
    end
  endtask

  task automatic test_sweep();
    logic [383:0] x;
    logic [383:0] y;
    for (int i = 0; i < 500; i++) begin
      x = rand_op(12);
      y = rand_op(12);
      run_op(1, 4, x, y, clmul_ref(x, y), "sweep_12_1");
    end
    for (int i = 0; i < 500; i++) begin
      x = rand_op(12);
      y = rand_op(12);
      run_op(2, 1, x, y, clmul_ref(x, y), "sweep_12_4");
    end
    for (int i = 0; i < 500; i++) begin
      x = rand_op(384);
      y = rand_op(384);
      run_op(3, 16, x, y, clmul_ref(x, y), "sweep_384_8");
    end
  endtask

  initial begin
    test_reset();
    test_simple();
    test_corners();
    test_back_to_back();
    test_random_default();
    test_ignored_start();
    test_reset_mid_op();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/toom3_gf2_mult_seq.md
# toom3_gf2_mult_seq

Parametrised, multi-cycle carry-less multiplier over GF(2)[x] that uses a 3-way operand split. It accepts two WIDTH-bit binary polynomials under a start/ready handshake. Nine sub-products are computed DIGIT bits per cycle, folded into five coefficient terms, and the 2·WIDTH-bit product is delivered with a one-cycle done pulse. It is the handshaked, width/throughput-configurable successor of the fixed 192-bit 3-way multiplier, for use inside field-arithmetic datapaths (ECC/PQC cores).

## Interface
- WIDTH, 192, operand width in bits; must be a multiple of 3; S = WIDTH/3 is the limb width.
- DIGIT, 4, bits of each a-limb consumed per cycle; must divide S; K = S/DIGIT digit steps.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when ready=1.
- a  in  WIDTH  operand A; limbs a0=a[S-1:0], a1=a[2S-1:S], a2=a[3S-1:2S].
- b  in  WIDTH  operand B; limbs b0, b1, b2 split the same way.
- ready  out  1  high in IDLE only; block accepts start.
- done  out  1  one-cycle pulse; c valid and new.
- c  out  2·WIDTH  product a·b over GF(2); holds until overwritten.

## Operation
- All arithmetic is XOR/AND; there are no carries.
- FSM states: IDLE, MUL, COMB, OUT.
- IDLE: ready=1. On start=1:
  - capture a and b into internal registers;
  - clear the nine accumulators p_ij (i,j∈{0,1,2}), each 2S-1 bits;
  - clear digit counter cnt;
  - go to MUL.
- MUL, one step per cycle:
  - p_ij ^= clmul(a_i[cnt·DIGIT +: DIGIT], b_j) << (cnt·DIGIT), for all nine pairs in parallel;
  - increment cnt;
  - after step cnt=K-1, go to COMB.
- COMB, in one cycle:
  - h = p00
  - g = p01^p10
  - f = p02^p11^p20
  - e = p12^p21
  - d = p22
  - each term is registered at 2S-1 bits; then go to OUT.
- OUT, in one cycle:
  - c <= h ^ (g<<S) ^ (f<<2S) ^ (e<<3S) ^ (d<<4S), truncated to 2·WIDTH bits; the top bit is always 0;
  - done <= 1;
  - go to IDLE.
- start while ready=0 is ignored; no queueing, no error flag.
- Inputs a and b may change freely after the accept edge; only the captured copies are used.
- Counter width is clog2(K)+1. cnt never exceeds K-1, and no bit index past S-1 is ever read.

## Timing
- Reset values: ready=1, done=0, c=0. State=IDLE, cnt=0, all accumulators and terms =0.
- Latency: with start accepted at edge T, done=1 and c valid in the cycle following edge T+K+2. For the default configuration (K=16) that is edge T+18.
- Occupancy: the block is busy for K+2 cycles.
- ready rises in the same cycle done is high, so start may be accepted in that cycle (back-to-back). Throughput is one result per K+2 cycles.
- done is high for exactly one cycle per accepted start.
- c changes only on the OUT edge or on reset.
- Reset mid-operation (any state):
  - the next edge returns to IDLE with c=0 and done=0;
  - the aborted result is never signalled.
- rst has priority over start in the same cycle.

## Test plan
- Reset: hold rst 3 cycles, then release with start=0 for 20 cycles. Required: ready=1, done=0 and c=0 throughout.
- Simple products (default parameters):
  - a=1, b=1 → c=1 with done at T+18;
  - a=3, b=3 → c=5.
- Corner bits: a=b=2^191 → c=2^382. Then a=2^191, b=1 → c=2^191.
- Squaring: a=b=2^192−1 → c has exactly the even bits 0,2,…,382 set. Issue a second start in the done cycle with a=0, b=2^192−1. Required: accepted immediately, c=0 at done 18 cycles later.
- Handshake and reset:
  - pulse start at cycles T+3 and T+10 of a busy operation → ignored, exactly one done;
  - assert rst at T+8 → no done, c=0, ready=1 after the reset edge.
- Parameter sweep: WIDTH=12/DIGIT=1, WIDTH=12/DIGIT=4 and WIDTH=384/DIGIT=8, each with 500 random operand pairs. Compare against a bitwise carry-less reference model. Required: exact match, and done at T+K+2 in every case.
